// File: rtl/mp_tdm_mem_pkg.sv
// mp_tdm_mem_pkg -- shared definitions for the TDM multi-read-port memory.
//   Frame layout: phase 0 captures requests, phases 1..NUM_RPORTS perform one
//   read each, phase F-1 performs the write and publishes read data.
//   MP_SLICE(bus,k,w) selects lane k of a flat packed multi-port bus.
`ifndef MP_TDM_MEM_PKG_SV
`define MP_TDM_MEM_PKG_SV

`define MP_SLICE(bus, k, w) bus[(k)*(w) +: (w)]

package mp_tdm_mem_pkg;

    localparam int PH_CAPTURE = 0;   // request registers load leaving this phase
    localparam int PH_RD_BASE = 1;   // read port k is served leaving phase PH_RD_BASE+k

    // One capture phase, one phase per read port, one commit phase.
    function automatic int frame_len(input int nrp);
        return nrp + 2;
    endfunction

    function automatic int phase_w(input int f);
        return (f <= 2) ? 1 : $clog2(f);
    endfunction

    function automatic int idx_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

`endif

// File: rtl/tdm_phase_gen.sv
// tdm_phase_gen -- free-running frame phase counter.
//   clk, rst_n      : clock, async active-low reset
//   o_phase         : current phase 0..F-1, never stalls
//   o_frame_start   : high while phase == 0 (combinational)
//   o_internal_clk  : registered slow clock, high for phases 0..F/2-1
module tdm_phase_gen #(
    parameter int F  = 4,
    parameter int PW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [PW-1:0] o_phase,
    output logic          o_frame_start,
    output logic          o_internal_clk
);

    localparam logic [PW-1:0] PH_LAST = PW'(F - 1);
    localparam logic [PW-1:0] HALF    = PW'(F / 2);

    logic [PW-1:0] r_phase;
    logic          r_iclk;
    logic [PW-1:0] w_nphase;

    assign w_nphase = (r_phase == PH_LAST) ? '0 : r_phase + PW'(1);

    // internal_clk is decoded from the next phase so it lines up with the
    // phase it describes without a combinational path to the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= '0;
            r_iclk  <= 1'b0;
        end else begin
            r_phase <= w_nphase;
            r_iclk  <= (w_nphase < HALF);
        end
    end

    assign o_phase        = r_phase;
    assign o_frame_start  = (r_phase == '0);
    assign o_internal_clk = r_iclk;

endmodule

// File: rtl/mp_tdm_mem.sv
// mp_tdm_mem -- multi-read-port memory built from one single-port array by
//   time-division multiplexing over a frame of F = NUM_RPORTS+2 cycles.
//   clk, rst_n     : clock, async active-low reset
//   internal_clk   : slow clock, period F
//   frame_start    : high during phase 0
//   raddr / rdata  : packed per-port read address / data (port k at k*W)
//   waddr, write, wdata : single write port
//   Read latency is one frame; rdata holds for a whole frame.
module mp_tdm_mem
    import mp_tdm_mem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 256,
    parameter int NUM_RPORTS = 2,
    parameter int BYPASS     = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic                         internal_clk,
    output logic                         frame_start,
    input  logic [NUM_RPORTS*ADDR_W-1:0] raddr,
    output logic [NUM_RPORTS*DATA_W-1:0] rdata,
    input  logic [ADDR_W-1:0]            waddr,
    input  logic                         write,
    input  logic [DATA_W-1:0]            wdata
);

    localparam int              F       = frame_len(NUM_RPORTS);
    localparam int              PW      = phase_w(F);
    localparam int              IW      = idx_w(DEPTH);
    localparam logic [PW-1:0]   PH_CAP  = PW'(PH_CAPTURE);
    localparam logic [PW-1:0]   PH_LAST = PW'(F - 1);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [PW-1:0] w_phase;

    tdm_phase_gen #(.F(F), .PW(PW)) u_phase (
        .clk            (clk),
        .rst_n          (rst_n),
        .o_phase        (w_phase),
        .o_frame_start  (frame_start),
        .o_internal_clk (internal_clk)
    );

    // Storage is deliberately not reset.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [NUM_RPORTS-1:0][ADDR_W-1:0] r_raddr;
    logic [ADDR_W-1:0]                 r_waddr;
    logic                              r_we;
    logic [DATA_W-1:0]                 r_wdata;
    logic [NUM_RPORTS-1:0][DATA_W-1:0] r_rbuf;
    logic [NUM_RPORTS-1:0][DATA_W-1:0] r_rdata;

    logic [ADDR_W-1:0] w_rd_addr;
    logic [DATA_W-1:0] w_rd_word;
    logic              w_rd_inr;
    logic              w_wr_inr;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_L;
    endfunction

    // Address of the port being served this phase; only one port per cycle.
    always_comb begin
        w_rd_addr = '0;
        for (int k = 0; k < NUM_RPORTS; k++) begin
            if (w_phase == PW'(PH_RD_BASE + k)) w_rd_addr = r_raddr[k];
        end
    end

    assign w_rd_inr = in_range(w_rd_addr);
    assign w_wr_inr = in_range(r_waddr);

    // Out-of-range reads return 0 even when they match the write address,
    // since that write is dropped as well.
    always_comb begin
        w_rd_word = '0;
        if (w_rd_inr) begin
            if (BYPASS != 0 && r_we && r_waddr == w_rd_addr) w_rd_word = r_wdata;
            else                                             w_rd_word = mem[w_rd_addr[IW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raddr <= '0;
            r_waddr <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_rbuf  <= '0;
            r_rdata <= '0;
        end else begin
            if (w_phase == PH_CAP) begin
                for (int k = 0; k < NUM_RPORTS; k++)
                    r_raddr[k] <= `MP_SLICE(raddr, k, ADDR_W);
                r_waddr <= waddr;
                r_we    <= write;
                r_wdata <= wdata;
            end
            for (int k = 0; k < NUM_RPORTS; k++) begin
                if (w_phase == PW'(PH_RD_BASE + k)) r_rbuf[k] <= w_rd_word;
            end
            if (w_phase == PH_LAST) r_rdata <= r_rbuf;
        end
    end

    // Write sits in the last phase, after every read of the frame (read-first).
    // Reset holds phase at 0 and clears r_we, so an interrupted frame never writes.
    always_ff @(posedge clk) begin
        if (w_phase == PH_LAST && r_we && w_wr_inr)
            mem[r_waddr[IW-1:0]] <= r_wdata;
    end

    for (genvar k = 0; k < NUM_RPORTS; k++) begin : g_rd
        assign `MP_SLICE(rdata, k, DATA_W) = r_rdata[k];
    end

endmodule

// File: tb/tb_mp_tdm_mem.sv
// tb_mp_tdm_mem -- directed bench: two 2-port instances (read-first with
// DEPTH=200, and bypass) share stimulus; an 8-port instance checks wide frames.
module tb_mp_tdm_mem;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [15:0]  raddr;
    logic [7:0]   waddr;
    logic         write;
    logic [31:0]  wdata;
    logic [63:0]  rdata_a, rdata_b;
    logic         fs_a, fs_b, ic_a, ic_b;

    logic [63:0]  raddr_c;
    logic [7:0]   waddr_c;
    logic         write_c;
    logic [31:0]  wdata_c;
    logic [255:0] rdata_c;
    logic         fs_c, ic_c;

    int n_chk = 0;
    int n_err = 0;

    mp_tdm_mem #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .NUM_RPORTS(2), .BYPASS(0)) u_a (
        .clk(clk), .rst_n(rst_n), .internal_clk(ic_a), .frame_start(fs_a),
        .raddr(raddr), .rdata(rdata_a), .waddr(waddr), .write(write), .wdata(wdata));

    mp_tdm_mem #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .NUM_RPORTS(2), .BYPASS(1)) u_b (
        .clk(clk), .rst_n(rst_n), .internal_clk(ic_b), .frame_start(fs_b),
        .raddr(raddr), .rdata(rdata_b), .waddr(waddr), .write(write), .wdata(wdata));

    mp_tdm_mem #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .NUM_RPORTS(8), .BYPASS(0)) u_c (
        .clk(clk), .rst_n(rst_n), .internal_clk(ic_c), .frame_start(fs_c),
        .raddr(raddr_c), .rdata(rdata_c), .waddr(waddr_c), .write(write_c), .wdata(wdata_c));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one request at phase 0 of instances a/b, then junk (including a
    // write) in phases 1..3 that must be ignored. Returns rdata seen at phase 0
    // (previous frame's result), whether it held for the frame, and the
    // per-phase frame_start / internal_clk pattern of instance a.
    task automatic frame(input logic [7:0] ra0, input logic [7:0] ra1, input logic we,
                         input logic [7:0] wa, input logic [31:0] wd,
                         output logic [63:0] pa, output logic [63:0] pb,
                         output logic stable, output logic [3:0] fsq, output logic [3:0] icq);
        int n;
        n = 0;
        @(negedge clk);
        while (!fs_a && n < 20) begin @(negedge clk); n++; end
        chk("fs_a_seen", {63'd0, fs_a}, 64'd1);
        pa = rdata_a; pb = rdata_b; stable = 1'b1;
        fsq[0] = fs_a; icq[0] = ic_a;
        raddr = {ra1, ra0}; waddr = wa; write = we; wdata = wd;
        for (int p = 1; p < 4; p++) begin
            @(negedge clk);
            raddr = ~{ra1, ra0}; waddr = 8'h3F; write = 1'b1; wdata = 32'hBAD0BAD0;
            fsq[p] = fs_a; icq[p] = ic_a;
            if (rdata_a !== pa || rdata_b !== pb) stable = 1'b0;
        end
    endtask

    task automatic frame_c(input logic [63:0] ra, input logic we, input logic [7:0] wa,
                           input logic [31:0] wd, output logic [255:0] prev,
                           output logic [9:0] fsq, output logic [9:0] icq);
        int n;
        n = 0;
        @(negedge clk);
        while (!fs_c && n < 30) begin @(negedge clk); n++; end
        chk("fs_c_seen", {63'd0, fs_c}, 64'd1);
        prev = rdata_c;
        fsq[0] = fs_c; icq[0] = ic_c;
        raddr_c = ra; write_c = we; waddr_c = wa; wdata_c = wd;
        for (int p = 1; p < 10; p++) begin
            @(negedge clk);
            raddr_c = ~ra; write_c = 1'b1; waddr_c = 8'h20; wdata_c = 32'hBAD0BAD0;
            fsq[p] = fs_c; icq[p] = ic_c;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0]  pa, pb;
        logic         st;
        logic [3:0]   fsq, icq;
        logic [255:0] pc;
        logic [9:0]   fsq_c, icq_c;
        logic [31:0]  exp_w;

        rst_n = 1'b0;
        raddr = '0; waddr = '0; write = 1'b0; wdata = '0;
        raddr_c = '0; waddr_c = '0; write_c = 1'b0; wdata_c = '0;
        repeat (3) @(negedge clk);
        chk("rst_rdata_a", rdata_a, 64'd0);
        chk("rst_rdata_b", rdata_b, 64'd0);
        chk("rst_rdata_c", rdata_c[63:0], 64'd0);
        chk("rst_fs", {63'd0, fs_a}, 64'd1);
        chk("rst_iclk", {63'd0, ic_a}, 64'd0);
        rst_n = 1'b1;

        frame(8'h00, 8'h00, 1'b1, 8'h05, 32'h12345678, pa, pb, st, fsq, icq);
        frame(8'h05, 8'h05, 1'b1, 8'h07, 32'h11111111, pa, pb, st, fsq, icq);
        frame(8'h05, 8'h07, 1'b1, 8'h3F, 32'h0C0C0C0C, pa, pb, st, fsq, icq);
        chk("wr_rd_a", pa, {32'h12345678, 32'h12345678});
        chk("wr_rd_b", pb, {32'h12345678, 32'h12345678});
        chk("wr_rd_stable", {63'd0, st}, 64'd1);
        frame(8'h07, 8'h3F, 1'b1, 8'h07, 32'hA5A5A5A5, pa, pb, st, fsq, icq);
        chk("two_addr_a", pa, {32'h11111111, 32'h12345678});
        frame(8'h07, 8'h07, 1'b1, 8'hC7, 32'h5555AAAA, pa, pb, st, fsq, icq);
        chk("rd_first_a", pa, {32'h0C0C0C0C, 32'h11111111});
        chk("bypass_b", pb, {32'h0C0C0C0C, 32'hA5A5A5A5});
        chk("frame_start_seq", {60'd0, fsq}, 64'h1);
        chk("iclk_seq", {60'd0, icq}, 64'h3);
        frame(8'hC8, 8'hC7, 1'b1, 8'hC8, 32'hFFFFFFFF, pa, pb, st, fsq, icq);
        chk("wr_landed_a", pa, {32'hA5A5A5A5, 32'hA5A5A5A5});
        chk("wr_landed_b", pb, {32'hA5A5A5A5, 32'hA5A5A5A5});
        frame(8'hC7, 8'hC8, 1'b1, 8'h10, 32'h01020304, pa, pb, st, fsq, icq);
        chk("oob_rd_a", pa, {32'h5555AAAA, 32'h00000000});
        chk("inrange_bypass_b", pb, {32'h5555AAAA, 32'hFFFFFFFF});
        frame(8'h10, 8'h00, 1'b0, 8'h00, 32'h0, pa, pb, st, fsq, icq);
        chk("oob_wr_ignored_a", pa, {32'h00000000, 32'h5555AAAA});
        chk("wr_b_c8", pb, {32'hFFFFFFFF, 32'h5555AAAA});

        // Reset after the phase-0 capture of a write to 0x10.
        @(negedge clk);
        chk("pre_rst_0x10", {32'd0, rdata_a[31:0]}, {32'd0, 32'h01020304});
        raddr = 16'h0000; waddr = 8'h10; write = 1'b1; wdata = 32'hDEADBEEF;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rdata_a", rdata_a, 64'd0);
        @(negedge clk);
        chk("mid_rst_rdata_b", rdata_b, 64'd0);
        raddr = {8'h10, 8'h10}; write = 1'b0; waddr = 8'h00; wdata = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_zero", rdata_a, 64'd0);
        frame(8'h10, 8'h10, 1'b0, 8'h00, 32'h0, pa, pb, st, fsq, icq);
        chk("rst_no_write_a", pa, {32'h01020304, 32'h01020304});
        chk("rst_no_write_b", pb, {32'h01020304, 32'h01020304});

        // Eight-port instance: fill 0x20..0x27, then read them permuted.
        for (int k = 0; k < 8; k++)
            frame_c(64'd0, 1'b1, 8'h20 + 8'(k), 32'hC0DE0000 + 32'(k) * 32'h1111, pc, fsq_c, icq_c);
        for (int k = 0; k < 8; k++) `MP_SLICE(raddr_c, k, 8) = 8'h27 - 8'(k);
        frame_c(raddr_c, 1'b0, 8'h00, 32'h0, pc, fsq_c, icq_c);
        frame_c(64'd0, 1'b0, 8'h00, 32'h0, pc, fsq_c, icq_c);
        for (int k = 0; k < 8; k++) begin
            exp_w = 32'hC0DE0000 + 32'(7 - k) * 32'h1111;
            chk($sformatf("c_port%0d", k), {32'd0, `MP_SLICE(pc, k, 32)}, {32'd0, exp_w});
        end
        chk("c_frame_start_seq", {54'd0, fsq_c}, 64'h001);
        chk("c_iclk_seq", {54'd0, icq_c}, 64'h01F);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
